// File: rtl/video_timing_analyzer_if.sv
// Parallel RGB video input bundle plus the timing measurements the analyzer reports back.
// The source side (video generator or bench) uses master; the analyzer uses slave.
interface video_timing_analyzer_if #(
  parameter int HCOUNTER_BITS = 12,
  parameter int VCOUNTER_BITS = 11
);
  logic [23:0]              video_data;
  logic                     video_de;
  logic                     video_hsync;
  logic                     video_vsync;
  logic [HCOUNTER_BITS-1:0] meas_hsync;
  logic [HCOUNTER_BITS-1:0] meas_hback;
  logic [HCOUNTER_BITS-1:0] meas_hactive;
  logic [HCOUNTER_BITS-1:0] meas_htotal;
  logic [VCOUNTER_BITS-1:0] meas_vsync;
  logic [VCOUNTER_BITS-1:0] meas_vback;
  logic [VCOUNTER_BITS-1:0] meas_vactive;
  logic [VCOUNTER_BITS-1:0] meas_vtotal;
  logic [31:0]              meas_checksum;
  logic                     meas_valid;
  logic                     meas_error;
  logic                     locked;

  modport master (
    output video_data, video_de, video_hsync, video_vsync,
    input  meas_hsync, meas_hback, meas_hactive, meas_htotal,
    input  meas_vsync, meas_vback, meas_vactive, meas_vtotal,
    input  meas_checksum, meas_valid, meas_error, locked
  );

  modport slave (
    input  video_data, video_de, video_hsync, video_vsync,
    output meas_hsync, meas_hback, meas_hactive, meas_htotal,
    output meas_vsync, meas_vback, meas_vactive, meas_vtotal,
    output meas_checksum, meas_valid, meas_error, locked
  );
endinterface

// File: rtl/video_timing_analyzer.sv
// Measures horizontal/vertical timing and a pixel checksum of an incoming RGB stream,
// reporting one result per frame and declaring lock once consecutive frames agree.
module video_timing_analyzer #(
  parameter int HCOUNTER_BITS     = 12,
  parameter int VCOUNTER_BITS     = 11,
  parameter int LOCK_FRAMES       = 2,
  parameter bit HSYNC_ACTIVE_HIGH = 1'b1,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input logic                    clock,
  input logic                    reset_n,
  video_timing_analyzer_if.slave vif
);
  localparam int HB = HCOUNTER_BITS;
  localparam int VB = VCOUNTER_BITS;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HB-1:0] HMAX     = '1;
  localparam logic [VB-1:0] VMAX     = '1;
  localparam logic [MW-1:0] LOCK_CNT = MW'(LOCK_FRAMES);
  localparam logic [1:0]    SYNC_POL = {VSYNC_ACTIVE_HIGH, HSYNC_ACTIVE_HIGH};

  function automatic logic [HB-1:0] hinc(input logic [HB-1:0] v);
    return (v == HMAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [VB-1:0] vinc(input logic [VB-1:0] v);
    return (v == VMAX) ? v : v + 1'b1;
  endfunction

  logic [1:0] sync_raw, sync_norm;
  assign sync_raw = {vif.video_vsync, vif.video_hsync};
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync_pol
    assign sync_norm[gi] = SYNC_POL[gi] ? sync_raw[gi] : ~sync_raw[gi];
  end

  logic [23:0]   data_q, data_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d;
  logic [HB-1:0] h_cnt_q, h_cnt_d, hs_w_q, hs_w_d, hb_q, hb_d, ha_q, ha_d;
  logic          de_seen_q, de_seen_d, vs_line_q, vs_line_d;
  logic [VB-1:0] v_cnt_q, v_cnt_d, vs_cnt_q, vs_cnt_d, va_q, va_d, vb_q, vb_d;
  logic          vde_q, vde_d, href_q, href_d, dirty_q, dirty_d;
  logic [HB-1:0] ref_ht_q, ref_ht_d, ref_hs_q, ref_hs_d, ref_hb_q, ref_hb_d, ref_ha_q, ref_ha_d;
  logic [31:0]   cs_q, cs_d;
  logic          armed_q, armed_d, prev_ok_q, prev_ok_d;
  logic [MW-1:0] match_q, match_d;
  logic [HB-1:0] prev_ht_q, prev_ht_d, prev_ha_q, prev_ha_d;
  logic [VB-1:0] prev_vt_q, prev_vt_d, prev_va_q, prev_va_d;
  logic [HB-1:0] m_ht_q, m_ht_d, m_hs_q, m_hs_d, m_hb_q, m_hb_d, m_ha_q, m_ha_d;
  logic [VB-1:0] m_vt_q, m_vt_d, m_vs_q, m_vs_d, m_vb_q, m_vb_d, m_va_q, m_va_d;
  logic [31:0]   m_cs_q, m_cs_d;
  logic          m_valid_q, m_valid_d, m_err_q, m_err_d, locked_q, locked_d;

  logic          line_start, frame_start, timeout, hb_inc, ovf, capture, mism;
  logic          vb_cond, vovf, href_fin, vde_fin, dirty_fin, clean, same;
  logic [HB-1:0] ht_fin, hs_fin, hb_fin, ha_fin;
  logic [VB-1:0] vt_fin, vsn_fin, va_fin, vb_fin;
  logic [31:0]   cs_add;

  assign line_start  = hs_q & ~hs_prev_q;
  assign frame_start = line_start & vs_q & ~vs_line_q;
  assign timeout     = ~line_start & (h_cnt_q == HMAX - 1'b1);
  assign hb_inc      = ~hs_q & ~de_seen_q & ~de_q;
  assign ovf         = ~line_start & ((h_cnt_q == HMAX) | (hs_q & (hs_w_q == HMAX)) |
                                      (hb_inc & (hb_q == HMAX)) | (de_q & (ha_q == HMAX)));
  assign cs_add      = de_q ? {8'h00, data_q} : 32'h0;

  // The *_q line counters describe the line that ends at this line_start.
  assign capture  = line_start & de_seen_q & ~href_q;
  assign mism     = line_start & href_q &
                    ((h_cnt_q != ref_ht_q) | (hs_w_q != ref_hs_q) |
                     (de_seen_q & ((hb_q != ref_hb_q) | (ha_q != ref_ha_q))));
  assign ht_fin   = capture ? h_cnt_q : ref_ht_q;
  assign hs_fin   = capture ? hs_w_q  : ref_hs_q;
  assign hb_fin   = capture ? hb_q    : ref_hb_q;
  assign ha_fin   = capture ? ha_q    : ref_ha_q;
  assign href_fin = href_q | capture;

  assign vb_cond  = ~vs_line_q & ~de_seen_q & ~vde_q;
  assign vt_fin   = vinc(v_cnt_q);
  assign vsn_fin  = vs_line_q ? vinc(vs_cnt_q) : vs_cnt_q;
  assign va_fin   = de_seen_q ? vinc(va_q) : va_q;
  assign vb_fin   = vb_cond ? vinc(vb_q) : vb_q;
  assign vde_fin  = vde_q | de_seen_q;
  assign vovf     = line_start & ((v_cnt_q == VMAX) | (vs_line_q & (vs_cnt_q == VMAX)) |
                                  (de_seen_q & (va_q == VMAX)) | (vb_cond & (vb_q == VMAX)));
  assign dirty_fin = dirty_q | ovf | mism | vovf;
  assign clean     = ~dirty_fin & href_fin;
  assign same      = prev_ok_q & (ht_fin == prev_ht_q) & (ha_fin == prev_ha_q) &
                     (vt_fin == prev_vt_q) & (va_fin == prev_va_q);

  always_comb begin
    data_d    = vif.video_data;
    de_d      = vif.video_de;
    hs_d      = sync_norm[0];
    vs_d      = sync_norm[1];
    hs_prev_d = hs_q;
    vs_line_d = line_start ? vs_q : vs_line_q;

    if (line_start) begin
      h_cnt_d   = HB'(1);
      hs_w_d    = HB'(1);
      hb_d      = '0;
      ha_d      = HB'(de_q);
      de_seen_d = de_q;
    end else begin
      h_cnt_d   = hinc(h_cnt_q);
      hs_w_d    = hs_q ? hinc(hs_w_q) : hs_w_q;
      hb_d      = hb_inc ? hinc(hb_q) : hb_q;
      ha_d      = de_q ? hinc(ha_q) : ha_q;
      de_seen_d = de_seen_q | de_q;
    end

    v_cnt_d  = v_cnt_q;  vs_cnt_d = vs_cnt_q; va_d = va_q; vb_d = vb_q;
    vde_d    = vde_q;    href_d   = href_q;
    ref_ht_d = ref_ht_q; ref_hs_d = ref_hs_q; ref_hb_d = ref_hb_q; ref_ha_d = ref_ha_q;
    dirty_d  = dirty_q | ovf;
    cs_d     = cs_q + cs_add;
    if (frame_start) begin
      v_cnt_d  = '0; vs_cnt_d = '0; va_d = '0; vb_d = '0;
      vde_d    = 1'b0; href_d = 1'b0; dirty_d = 1'b0;
      ref_ht_d = '0; ref_hs_d = '0; ref_hb_d = '0; ref_ha_d = '0;
      cs_d     = cs_add;
    end else if (line_start) begin
      v_cnt_d  = vt_fin; vs_cnt_d = vsn_fin; va_d = va_fin; vb_d = vb_fin;
      vde_d    = vde_fin; href_d = href_fin; dirty_d = dirty_fin;
      ref_ht_d = ht_fin; ref_hs_d = hs_fin; ref_hb_d = hb_fin; ref_ha_d = ha_fin;
    end

    m_ht_d = m_ht_q; m_hs_d = m_hs_q; m_hb_d = m_hb_q; m_ha_d = m_ha_q;
    m_vt_d = m_vt_q; m_vs_d = m_vs_q; m_vb_d = m_vb_q; m_va_d = m_va_q;
    m_cs_d = m_cs_q; m_valid_d = 1'b0; m_err_d = m_err_q; locked_d = locked_q;
    armed_d = armed_q; match_d = match_q; prev_ok_d = prev_ok_q;
    prev_ht_d = prev_ht_q; prev_ha_d = prev_ha_q; prev_vt_d = prev_vt_q; prev_va_d = prev_va_q;
    if (timeout) begin
      armed_d   = 1'b0;
      locked_d  = 1'b0;
      m_err_d   = 1'b1;
      match_d   = '0;
      prev_ok_d = 1'b0;
    end else if (frame_start) begin
      armed_d = 1'b1;
      // The first frame start after reset/timeout only opens the measurement window.
      if (armed_q) begin
        m_ht_d = ht_fin; m_hs_d = hs_fin; m_hb_d = hb_fin; m_ha_d = ha_fin;
        m_vt_d = vt_fin; m_vs_d = vsn_fin; m_vb_d = vb_fin; m_va_d = va_fin;
        m_cs_d = cs_q; m_valid_d = 1'b1; m_err_d = ~clean;
        if (clean) begin
          prev_ok_d = 1'b1;
          prev_ht_d = ht_fin; prev_ha_d = ha_fin; prev_vt_d = vt_fin; prev_va_d = va_fin;
          match_d   = same ? ((match_q >= LOCK_CNT) ? match_q : match_q + 1'b1) : MW'(1);
        end else begin
          prev_ok_d = 1'b0;
          match_d   = '0;
        end
        locked_d = clean & (match_d >= LOCK_CNT);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0; de_q <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0; hs_prev_q <= 1'b0;
      h_cnt_q <= '0; hs_w_q <= '0; hb_q <= '0; ha_q <= '0; de_seen_q <= 1'b0; vs_line_q <= 1'b0;
      v_cnt_q <= '0; vs_cnt_q <= '0; va_q <= '0; vb_q <= '0;
      vde_q <= 1'b0; href_q <= 1'b0; dirty_q <= 1'b0; cs_q <= '0;
      ref_ht_q <= '0; ref_hs_q <= '0; ref_hb_q <= '0; ref_ha_q <= '0;
      armed_q <= 1'b0; match_q <= '0; prev_ok_q <= 1'b0;
      prev_ht_q <= '0; prev_ha_q <= '0; prev_vt_q <= '0; prev_va_q <= '0;
      m_ht_q <= '0; m_hs_q <= '0; m_hb_q <= '0; m_ha_q <= '0;
      m_vt_q <= '0; m_vs_q <= '0; m_vb_q <= '0; m_va_q <= '0;
      m_cs_q <= '0; m_valid_q <= 1'b0; m_err_q <= 1'b0; locked_q <= 1'b0;
    end else begin
      data_q <= data_d; de_q <= de_d; hs_q <= hs_d; vs_q <= vs_d; hs_prev_q <= hs_prev_d;
      h_cnt_q <= h_cnt_d; hs_w_q <= hs_w_d; hb_q <= hb_d; ha_q <= ha_d;
      de_seen_q <= de_seen_d; vs_line_q <= vs_line_d;
      v_cnt_q <= v_cnt_d; vs_cnt_q <= vs_cnt_d; va_q <= va_d; vb_q <= vb_d;
      vde_q <= vde_d; href_q <= href_d; dirty_q <= dirty_d; cs_q <= cs_d;
      ref_ht_q <= ref_ht_d; ref_hs_q <= ref_hs_d; ref_hb_q <= ref_hb_d; ref_ha_q <= ref_ha_d;
      armed_q <= armed_d; match_q <= match_d; prev_ok_q <= prev_ok_d;
      prev_ht_q <= prev_ht_d; prev_ha_q <= prev_ha_d; prev_vt_q <= prev_vt_d; prev_va_q <= prev_va_d;
      m_ht_q <= m_ht_d; m_hs_q <= m_hs_d; m_hb_q <= m_hb_d; m_ha_q <= m_ha_d;
      m_vt_q <= m_vt_d; m_vs_q <= m_vs_d; m_vb_q <= m_vb_d; m_va_q <= m_va_d;
      m_cs_q <= m_cs_d; m_valid_q <= m_valid_d; m_err_q <= m_err_d; locked_q <= locked_d;
    end
  end

  assign vif.meas_htotal   = m_ht_q;
  assign vif.meas_hsync    = m_hs_q;
  assign vif.meas_hback    = m_hb_q;
  assign vif.meas_hactive  = m_ha_q;
  assign vif.meas_vtotal   = m_vt_q;
  assign vif.meas_vsync    = m_vs_q;
  assign vif.meas_vback    = m_vb_q;
  assign vif.meas_vactive  = m_va_q;
  assign vif.meas_checksum = m_cs_q;
  assign vif.meas_valid    = m_valid_q;
  assign vif.meas_error    = m_err_q;
  assign vif.locked        = locked_q;
endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench: a 28x14 test format drives an active-high analyzer and an active-low one
// in parallel; each reported frame is compared against hand-computed timing and a pixel sum.
`timescale 1ns/1ps
module tb_video_timing_analyzer;
  localparam int HCB = 12;
  localparam int VCB = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data = '0;
  logic        de = 1'b0, hs = 1'b0, vs = 1'b0;

  int          checks = 0, failures = 0;
  int          valid_cnt = 0, valid_cnt_b = 0, valid_base = 0;
  int          frame_no = 0;
  logic [31:0] last_sum = '0, prev_sum = '0;
  logic [31:0] snap_a [0:10];
  logic [31:0] snap_b [0:10];
  // htotal, hsync, hback, hactive, vtotal, vsync, vback, vactive of the test format
  int          exp_vals [0:7] = '{28, 4, 6, 16, 14, 2, 3, 8};
  string       names [0:7] = '{"htotal", "hsync", "hback", "hactive",
                               "vtotal", "vsync", "vback", "vactive"};

  always #5 clk = ~clk;

  video_timing_analyzer_if #(.HCOUNTER_BITS(HCB), .VCOUNTER_BITS(VCB)) vif_a ();
  video_timing_analyzer_if #(.HCOUNTER_BITS(HCB), .VCOUNTER_BITS(VCB)) vif_b ();

  assign vif_a.video_data  = data;
  assign vif_a.video_de    = de;
  assign vif_a.video_hsync = hs;
  assign vif_a.video_vsync = vs;
  assign vif_b.video_data  = data;
  assign vif_b.video_de    = de;
  assign vif_b.video_hsync = ~hs;
  assign vif_b.video_vsync = ~vs;

  video_timing_analyzer #(
    .HCOUNTER_BITS(HCB), .VCOUNTER_BITS(VCB), .LOCK_FRAMES(2),
    .HSYNC_ACTIVE_HIGH(1'b1), .VSYNC_ACTIVE_HIGH(1'b1)
  ) dut_a (.clock(clk), .reset_n(rst_n), .vif(vif_a));

  video_timing_analyzer #(
    .HCOUNTER_BITS(HCB), .VCOUNTER_BITS(VCB), .LOCK_FRAMES(2),
    .HSYNC_ACTIVE_HIGH(1'b0), .VSYNC_ACTIVE_HIGH(1'b0)
  ) dut_b (.clock(clk), .reset_n(rst_n), .vif(vif_b));

  always @(negedge clk) begin
    if (vif_a.meas_valid === 1'b1) begin
      snap_a[0]  <= 32'(vif_a.meas_htotal);  snap_a[1] <= 32'(vif_a.meas_hsync);
      snap_a[2]  <= 32'(vif_a.meas_hback);   snap_a[3] <= 32'(vif_a.meas_hactive);
      snap_a[4]  <= 32'(vif_a.meas_vtotal);  snap_a[5] <= 32'(vif_a.meas_vsync);
      snap_a[6]  <= 32'(vif_a.meas_vback);   snap_a[7] <= 32'(vif_a.meas_vactive);
      snap_a[8]  <= vif_a.meas_checksum;     snap_a[9] <= 32'(vif_a.meas_error);
      snap_a[10] <= 32'(vif_a.locked);
      valid_cnt  <= valid_cnt + 1;
      $display("txn %0d: htotal=%0d hactive=%0d vtotal=%0d vactive=%0d checksum=%08h error=%0d locked=%0d",
               valid_cnt + 1, vif_a.meas_htotal, vif_a.meas_hactive, vif_a.meas_vtotal,
               vif_a.meas_vactive, vif_a.meas_checksum, vif_a.meas_error, vif_a.locked);
    end
    if (vif_b.meas_valid === 1'b1) begin
      snap_b[0]  <= 32'(vif_b.meas_htotal);  snap_b[1] <= 32'(vif_b.meas_hsync);
      snap_b[2]  <= 32'(vif_b.meas_hback);   snap_b[3] <= 32'(vif_b.meas_hactive);
      snap_b[4]  <= 32'(vif_b.meas_vtotal);  snap_b[5] <= 32'(vif_b.meas_vsync);
      snap_b[6]  <= 32'(vif_b.meas_vback);   snap_b[7] <= 32'(vif_b.meas_vactive);
      snap_b[8]  <= vif_b.meas_checksum;     snap_b[9] <= 32'(vif_b.meas_error);
      snap_b[10] <= 32'(vif_b.locked);
      valid_cnt_b <= valid_cnt_b + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string pfx, input logic [31:0] snap [0:10],
                             input logic [31:0] exp_sum, input logic exp_err, input logic exp_lock);
    for (int i = 0; i < 8; i++) check_val({pfx, "_", names[i]}, snap[i], 32'(exp_vals[i]));
    check_val({pfx, "_checksum"}, snap[8], exp_sum);
    check_val({pfx, "_error"}, snap[9], 32'(exp_err));
    check_val({pfx, "_locked"}, snap[10], 32'(exp_lock));
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_htotal"}, 32'(vif_a.meas_htotal), 0);
    check_val({pfx, "_vtotal"}, 32'(vif_a.meas_vtotal), 0);
    check_val({pfx, "_checksum"}, vif_a.meas_checksum, 0);
    check_val({pfx, "_valid"}, 32'(vif_a.meas_valid), 0);
    check_val({pfx, "_error"}, 32'(vif_a.meas_error), 0);
    check_val({pfx, "_locked"}, 32'(vif_a.locked), 0);
  endtask

  task automatic send_line(input int ht, input int l);
    for (int c = 0; c < ht; c++) begin
      @(negedge clk);
      hs = (c < 4);
      vs = (l < 2);
      de = (l >= 5) && (l < 13) && (c >= 10) && (c < 26);
      if (de) begin
        data = 24'(frame_no * 40503 + l * 4099 + c * 263 + 1);
        last_sum = last_sum + 32'(data);
      end else begin
        data = '0;
      end
    end
  endtask

  task automatic send_frame(input int stretch_line, input int rst_line);
    prev_sum = last_sum;
    last_sum = '0;
    frame_no++;
    for (int l = 0; l < 14; l++) begin
      if (l == rst_line) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        valid_base = valid_cnt;
      end
      send_line((l == stretch_line) ? 29 : 28, l);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;

    send_frame(-1, -1);
    check_val("f1_no_valid", 32'(valid_cnt), 0);
    send_frame(-1, -1);
    check_val("f2_valid_cnt", 32'(valid_cnt), 1);
    check_frame("f1", snap_a, prev_sum, 1'b0, 1'b0);
    check_val("lowpol_valid_cnt", 32'(valid_cnt_b), 1);
    check_frame("lowpol_f1", snap_b, prev_sum, 1'b0, 1'b0);

    send_frame(-1, -1);
    check_val("f3_valid_cnt", 32'(valid_cnt), 2);
    check_frame("f2", snap_a, prev_sum, 1'b0, 1'b1);
    send_frame(8, -1);
    check_frame("f3", snap_a, prev_sum, 1'b0, 1'b1);
    send_frame(-1, -1);
    check_frame("f4_stretched", snap_a, prev_sum, 1'b1, 1'b0);
    send_frame(-1, -1);
    check_frame("f5", snap_a, prev_sum, 1'b0, 1'b0);
    send_frame(-1, -1);
    check_val("f7_valid_cnt", 32'(valid_cnt), 6);
    check_frame("f6_relock", snap_a, prev_sum, 1'b0, 1'b1);

    repeat (4200) @(negedge clk);
    check_val("timeout_locked", 32'(vif_a.locked), 0);
    check_val("timeout_error", 32'(vif_a.meas_error), 1);
    check_val("timeout_hold_htotal", 32'(vif_a.meas_htotal), 28);
    check_val("timeout_valid_cnt", 32'(valid_cnt), 6);
    send_frame(-1, -1);
    check_val("rearm_no_valid", 32'(valid_cnt), 6);
    send_frame(-1, -1);
    check_val("rearm_valid_cnt", 32'(valid_cnt), 7);
    check_frame("rearm", snap_a, prev_sum, 1'b0, 1'b0);

    send_frame(-1, 7);
    send_frame(-1, -1);
    check_val("postrst_no_valid", 32'(valid_cnt), 32'(valid_base));
    send_frame(-1, -1);
    check_val("postrst_valid_cnt", 32'(valid_cnt), 32'(valid_base + 1));
    check_frame("postrst", snap_a, prev_sum, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
